// File: rtl/pipeline_ctrl_stager_pkg.sv
// rtl/pipeline_ctrl_stager_pkg.sv - shared widths, bundle bit indices, forward selects and bubble values
// Purpose: common definitions for the control stager and its forwarding unit.
package pipeline_ctrl_stager_pkg;

    localparam int DEF_REG_AW  = 5;
    localparam int DEF_ALUOP_W = 3;

    // EX bundle {ALUop, ALUsrc, RegDst}
    localparam int REGDST = 0;
    localparam int ALUSRC = 1;

    // MEM bundle {MEM_cs, MEM_we}
    localparam int MEM_WE = 0;
    localparam int MEM_CS = 1;

    // WB bundle {WB_mux, Reg_we}
    localparam int REG_WE = 0;
    localparam int WB_MUX = 1;

    typedef enum logic [1:0] {
        FWD_REGFILE = 2'b00,
        FWD_MEMWB   = 2'b01,
        FWD_EXMEM   = 2'b10
    } fwd_sel_e;

    // A bubble clears every control bit, so no side-effect enable can fire.
    localparam logic [1:0] MEM_BUBBLE = 2'b00;
    localparam logic [1:0] WB_BUBBLE  = 2'b00;

endpackage

// File: rtl/pipeline_ctrl_stager_forward_unit.sv
// rtl/pipeline_ctrl_stager_forward_unit.sv - EX operand forwarding select for one source register
// Purpose: picks regfile / EX/MEM / MEM/WB for one EX operand.
// Ports:
//   i_src        EX-stage source register
//   i_exmem_we   EX/MEM Reg_we,  i_exmem_dst EX/MEM destination
//   i_memwb_we   MEM/WB Reg_we,  i_memwb_dst MEM/WB destination
//   o_sel        00 regfile, 10 EX/MEM, 01 MEM/WB
module pipeline_ctrl_stager_forward_unit
    import pipeline_ctrl_stager_pkg::*;
#(
    parameter int REG_AW = DEF_REG_AW
) (
    input  logic [REG_AW-1:0] i_src,
    input  logic              i_exmem_we,
    input  logic [REG_AW-1:0] i_exmem_dst,
    input  logic              i_memwb_we,
    input  logic [REG_AW-1:0] i_memwb_dst,
    output logic [1:0]        o_sel
);

    // r0 is hardwired zero, so it is never a forwarding source.
    // EX/MEM is checked first: it holds the younger, more recent value.
    always_comb begin
        o_sel = FWD_REGFILE;
        if (i_src != '0) begin
            if (i_exmem_we && (i_exmem_dst == i_src)) begin
                o_sel = FWD_EXMEM;
            end else if (i_memwb_we && (i_memwb_dst == i_src)) begin
                o_sel = FWD_MEMWB;
            end
        end
    end

endmodule

// File: rtl/pipeline_ctrl_stager.sv
// rtl/pipeline_ctrl_stager.sv - ID/EX, EX/MEM, MEM/WB control staging with hazard, flush and forwarding
// Purpose: carries decoder control bundles and dest tags down the pipe, stalls on
//   load-use, flushes IF/ID on taken jump/branch, and drives EX forwarding selects.
// Ports:
//   clk_i, rst_n_i (async active-low), hold_i (global freeze)
//   pc_ctrl_i, ex_ctrl_i, mem_ctrl_i, wb_ctrl_i, rs_i, rt_i, rd_i   from ID-stage decoder
//   ex_ctrl_o (ID/EX), mem_ctrl_o (EX/MEM), wb_ctrl_o/wb_dst_o (MEM/WB)
//   fwd_a_o, fwd_b_o  EX operand selects; stall_o, flush_o  IF/ID control
module pipeline_ctrl_stager
    import pipeline_ctrl_stager_pkg::*;
#(
    parameter int REG_AW  = DEF_REG_AW,
    parameter int ALUOP_W = DEF_ALUOP_W
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 hold_i,
    input  logic [1:0]           pc_ctrl_i,
    input  logic [ALUOP_W+1:0]   ex_ctrl_i,
    input  logic [1:0]           mem_ctrl_i,
    input  logic [1:0]           wb_ctrl_i,
    input  logic [REG_AW-1:0]    rs_i,
    input  logic [REG_AW-1:0]    rt_i,
    input  logic [REG_AW-1:0]    rd_i,
    output logic [ALUOP_W+1:0]   ex_ctrl_o,
    output logic [1:0]           mem_ctrl_o,
    output logic [1:0]           wb_ctrl_o,
    output logic [REG_AW-1:0]    wb_dst_o,
    output logic [1:0]           fwd_a_o,
    output logic [1:0]           fwd_b_o,
    output logic                 stall_o,
    output logic                 flush_o
);

    logic [ALUOP_W+1:0] r_idex_ex;
    logic [1:0]         r_idex_mem;
    logic [1:0]         r_idex_wb;
    logic [REG_AW-1:0]  r_idex_rs;
    logic [REG_AW-1:0]  r_idex_rt;
    logic [REG_AW-1:0]  r_idex_dst;

    logic [1:0]         r_exmem_mem;
    logic [1:0]         r_exmem_wb;
    logic [REG_AW-1:0]  r_exmem_dst;

    logic [1:0]         r_memwb_wb;
    logic [REG_AW-1:0]  r_memwb_dst;

    logic [REG_AW-1:0]  w_id_dst;
    logic               w_idex_load;
    logic               w_stall;

    assign w_id_dst    = ex_ctrl_i[REGDST] ? rd_i : rt_i;
    assign w_idex_load = r_idex_mem[MEM_CS] & ~r_idex_mem[MEM_WE];
    assign w_stall     = w_idex_load & (r_idex_dst != '0)
                       & ((r_idex_dst == rs_i) | (r_idex_dst == rt_i));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_idex_ex   <= '0;
            r_idex_mem  <= MEM_BUBBLE;
            r_idex_wb   <= WB_BUBBLE;
            r_idex_rs   <= '0;
            r_idex_rt   <= '0;
            r_idex_dst  <= '0;
            r_exmem_mem <= MEM_BUBBLE;
            r_exmem_wb  <= WB_BUBBLE;
            r_exmem_dst <= '0;
            r_memwb_wb  <= WB_BUBBLE;
            r_memwb_dst <= '0;
        end else if (!hold_i) begin
            // The load keeps moving while the dependent instruction waits in IF/ID.
            if (w_stall) begin
                r_idex_ex  <= '0;
                r_idex_mem <= MEM_BUBBLE;
                r_idex_wb  <= WB_BUBBLE;
                r_idex_rs  <= '0;
                r_idex_rt  <= '0;
                r_idex_dst <= '0;
            end else begin
                r_idex_ex  <= ex_ctrl_i;
                r_idex_mem <= mem_ctrl_i;
                r_idex_wb  <= wb_ctrl_i;
                r_idex_rs  <= rs_i;
                r_idex_rt  <= rt_i;
                r_idex_dst <= w_id_dst;
            end
            r_exmem_mem <= r_idex_mem;
            r_exmem_wb  <= r_idex_wb;
            r_exmem_dst <= r_idex_dst;
            r_memwb_wb  <= r_exmem_wb;
            r_memwb_dst <= r_exmem_dst;
        end
    end

    pipeline_ctrl_stager_forward_unit #(.REG_AW(REG_AW)) u_fwd_a (
        .i_src       (r_idex_rs),
        .i_exmem_we  (r_exmem_wb[REG_WE]),
        .i_exmem_dst (r_exmem_dst),
        .i_memwb_we  (r_memwb_wb[REG_WE]),
        .i_memwb_dst (r_memwb_dst),
        .o_sel       (fwd_a_o)
    );

    pipeline_ctrl_stager_forward_unit #(.REG_AW(REG_AW)) u_fwd_b (
        .i_src       (r_idex_rt),
        .i_exmem_we  (r_exmem_wb[REG_WE]),
        .i_exmem_dst (r_exmem_dst),
        .i_memwb_we  (r_memwb_wb[REG_WE]),
        .i_memwb_dst (r_memwb_dst),
        .o_sel       (fwd_b_o)
    );

    assign ex_ctrl_o  = r_idex_ex;
    assign mem_ctrl_o = r_exmem_mem;
    assign wb_ctrl_o  = r_memwb_wb;
    assign wb_dst_o   = r_memwb_dst;
    assign stall_o    = w_stall;
    // Stall wins: a branch behind an unresolved load cannot be redirected yet.
    // Gated by reset so the output is 0 while reset is asserted.
    assign flush_o    = rst_n_i & (|pc_ctrl_i) & ~w_stall;

endmodule
